// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared access-size codes and FSM state codes for the load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    // funct3 access-size codes (store variants share the signed codes)
    localparam logic [2:0] LSU_LB   = 3'd0;
    localparam logic [2:0] LSU_LH   = 3'd1;
    localparam logic [2:0] LSU_LW   = 3'd2;
    localparam logic [2:0] LSU_LBU  = 3'd4;
    localparam logic [2:0] LSU_LHU  = 3'd5;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_RESP = 2'd3;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational width rules: byte enables, store replication,
//            load extraction/extension and fault decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = 32'd0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            LSU_LB, LSU_LBU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7] & (i_funct3 == LSU_LB)}}, w_byte};
            end
            LSU_LH, LSU_LHU: begin
                o_be         = 4'b0011 << i_offset;
                o_misaligned = i_offset[0];
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{w_half[15] & (i_funct3 == LSU_LH)}}, w_half};
            end
            LSU_LW: begin
                o_be         = 4'b1111;
                o_misaligned = |i_offset;
                o_rdata      = i_rdata;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding memory-access stage with req/gnt/rvalid port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         mem_req,
    input  logic         mem_gnt,
    output logic         mem_we,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_misaligned,
    output logic         rsp_illegal
);

    logic [1:0]   r_state;
    logic [2:0]   r_funct3;
    logic [1:0]   r_offset;

    logic [2:0]   w_funct3;
    logic [1:0]   w_offset;
    logic [3:0]   w_be;
    logic [N-1:0] w_wdata;
    logic [N-1:0] w_rdata;
    logic         w_misaligned;
    logic         w_illegal;

    assign req_ready = (r_state == LSU_IDLE);

    // The aligner decodes the incoming request while idle and the latched access otherwise.
    assign w_funct3 = req_ready ? req_funct3    : r_funct3;
    assign w_offset = req_ready ? req_addr[1:0] : r_offset;

    lsu_align u_align (
        .i_funct3     (w_funct3),
        .i_offset     (w_offset),
        .i_wdata      (req_wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= LSU_IDLE;
            r_funct3       <= 3'd0;
            r_offset       <= 2'd0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_be         <= 4'b0000;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_funct3       <= req_funct3;
                        r_offset       <= req_addr[1:0];
                        mem_we         <= req_we;
                        mem_be         <= w_be;
                        mem_addr       <= {req_addr[N-1:2], 2'b00};
                        mem_wdata      <= w_wdata;
                        rsp_rdata      <= '0;
                        rsp_illegal    <= w_illegal;
                        rsp_misaligned <= w_misaligned & ~w_illegal;
                        // Faulting accesses never touch memory.
                        if (w_illegal || w_misaligned) begin
                            rsp_valid <= 1'b1;
                            r_state   <= LSU_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            r_state   <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            rsp_valid <= 1'b1;
                            r_state   <= LSU_RESP;
                        end else begin
                            r_state   <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_rdata <= w_rdata;
                        rsp_valid <= 1'b1;
                        r_state   <= LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    rsp_valid <= 1'b0;
                    r_state   <= LSU_IDLE;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a randomized memory responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } mexp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_illegal;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    auto_mem = 1'b1;
    bit    junk     = 1'b0;
    int    gmin = 0, gmax = 0, rmin = 0, rmax = 0;
    mexp_t exp_mem_q[$];
    rexp_t exp_rsp_q[$];
    logic [31:0] word_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: access size and signedness from funct3, then plain arithmetic on bytes.
    function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wdata, input bit [31:0] word,
                                  output bit access, output mexp_t m, output rexp_t r);
        int size;
        bit sgn;
        int off;
        longint unsigned mask, val;
        off = int'(addr[1:0]);
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        m = '0;
        r = '0;
        access = 1'b0;
        if (size == 0) begin
            r.ill = 1'b1;
        end else if (off % size != 0) begin
            r.mis = 1'b1;
        end else begin
            access = 1'b1;
            m.we   = we;
            m.addr = addr - 32'(off);
            m.be   = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
            if (!we) begin
                mask = (64'd1 << (8*size)) - 64'd1;
                val  = ({32'd0, word} >> (8*off)) & mask;
                if (sgn && val[8*size-1]) val = val | ~mask;
                r.rdata = val[31:0];
            end
        end
    endfunction

    // Waits for ready at a falling edge, presents one access for one cycle, records expectations.
    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit [31:0] word);
        bit    acc;
        mexp_t m;
        rexp_t r;
        int    guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        model(we, f3, addr, wdata, word, acc, m, r);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_rsp_q.push_back(r);
        if (acc) begin
            exp_mem_q.push_back(m);
            if (!we) word_q.push_back(word);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic run_directed(input string name, input bit we, input bit [2:0] f3,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                input bit [31:0] word, input int exp_lat,
                                output logic [31:0] rd, output logic mis, output logic ill);
        int lat = 1;
        bit saw_req = 1'b0;
        bit ready_seen = 1'b0;
        issue(we, f3, addr, wdata, word);
        while (!rsp_valid && lat < 100) begin
            saw_req    |= mem_req;
            ready_seen |= req_ready;
            @(negedge clk);
            lat++;
        end
        ready_seen |= req_ready;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_ready_low"}, 32'(ready_seen), 32'd0);
        check({name, "_mem_req_seen"}, 32'(saw_req), 32'(exp_lat > 1));
        rd  = rsp_rdata;
        mis = rsp_misaligned;
        ill = rsp_illegal;
    endtask

    // Memory responder: grants after a random delay, returns load data after a random delay.
    initial begin : responder
        int    gnt_cnt = -1;
        int    rv_cnt = 0;
        bit    rv_pend = 1'b0;
        bit    prev_pend = 1'b0;
        logic [31:0] rv_data = 32'd0;
        logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
        logic [4:0]  p_bewe = 5'd0;
        mexp_t m;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!auto_mem || !rst) begin
                gnt_cnt = -1;
                rv_pend = 1'b0;
                prev_pend = 1'b0;
            end else begin
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        rv_pend    = 1'b0;
                    end else begin
                        rv_cnt--;
                        mem_rdata = $urandom;
                    end
                end else if (mem_req) begin
                    if (prev_pend) begin
                        check("stable_addr", mem_addr, p_addr);
                        check("stable_wdata", mem_wdata, p_wdata);
                        check("stable_be_we", 32'({mem_be, mem_we}), 32'(p_bewe));
                    end
                    if (gnt_cnt < 0) gnt_cnt = $urandom_range(gmax, gmin);
                    if (gnt_cnt == 0) begin
                        mem_gnt   = 1'b1;
                        gnt_cnt   = -1;
                        prev_pend = 1'b0;
                        if (exp_mem_q.size() == 0) begin
                            check("unexpected_mem_req", 32'(mem_req), 32'd0);
                        end else begin
                            m = exp_mem_q.pop_front();
                            check("mem_addr", mem_addr, m.addr);
                            check("mem_be", 32'(mem_be), 32'(m.be));
                            check("mem_we", 32'(mem_we), 32'(m.we));
                            if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                            if (!m.we) begin
                                check("load_word_queue", 32'(word_q.size() > 0), 32'd1);
                                rv_data = (word_q.size() > 0) ? word_q.pop_front() : 32'd0;
                                rv_pend = 1'b1;
                                rv_cnt  = $urandom_range(rmax, rmin);
                            end
                        end
                    end else begin
                        gnt_cnt--;
                        prev_pend = 1'b1;
                        p_addr  = mem_addr;
                        p_wdata = mem_wdata;
                        p_bewe  = {mem_be, mem_we};
                        if (junk) begin
                            mem_rvalid = ($urandom_range(0, 3) == 0);
                            mem_rdata  = $urandom;
                        end
                    end
                end else begin
                    prev_pend = 1'b0;
                    if (junk) begin
                        mem_gnt    = ($urandom_range(0, 3) == 0);
                        mem_rvalid = ($urandom_range(0, 3) == 0);
                        mem_rdata  = $urandom;
                    end
                end
            end
        end
    end

    // Response monitor: every completion pops the oldest expectation.
    initial begin : monitor
        rexp_t r;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_misaligned", 32'(rsp_misaligned), 32'(r.mis));
                    check("rsp_illegal", 32'(rsp_illegal), 32'(r.ill));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] rd;
        logic        mis, ill;
        int          guard;
        #2 rst = 1'b0;
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_mem_ctl", 32'({mem_req, mem_we, mem_be}), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_rsp", 32'({rsp_valid, rsp_misaligned, rsp_illegal}), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_directed("lw", 1'b0, 3'd2, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 3, rd, mis, ill);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_mem_addr", mem_addr, 32'h0000_1004);
        check("lw_mem_be", 32'(mem_be), 32'hF);

        run_directed("lb", 1'b0, 3'd0, 32'h0000_2003, 32'd0, 32'h80FF_1234, 3, rd, mis, ill);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_mem_be", 32'(mem_be), 32'h8);
        run_directed("lbu", 1'b0, 3'd4, 32'h0000_2003, 32'd0, 32'h80FF_1234, 3, rd, mis, ill);
        check("lbu_rdata", rd, 32'h0000_0080);

        run_directed("sh", 1'b1, 3'd1, 32'h0000_3002, 32'h1234_BEEF, 32'd0, 2, rd, mis, ill);
        check("sh_mem_addr", mem_addr, 32'h0000_3000);
        check("sh_mem_be", 32'(mem_be), 32'hC);
        check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_mem_we", 32'(mem_we), 32'd1);
        check("sh_rdata", rd, 32'd0);

        run_directed("lw_mis", 1'b0, 3'd2, 32'h0000_1001, 32'd0, 32'd0, 1, rd, mis, ill);
        check("lw_mis_flags", 32'({mis, ill}), 32'b10);
        check("lw_mis_rdata", rd, 32'd0);
        run_directed("ill3", 1'b0, 3'd3, 32'h0000_1000, 32'd0, 32'd0, 1, rd, mis, ill);
        check("ill3_flags", 32'({mis, ill}), 32'b01);
        check("ill3_rdata", rd, 32'd0);
        run_directed("ill7_mis", 1'b1, 3'd7, 32'h0000_1003, 32'd0, 32'd0, 1, rd, mis, ill);
        check("ill7_priority", 32'({mis, ill}), 32'b01);

        gmin = 3; gmax = 3;
        run_directed("sw_stall", 1'b1, 3'd2, 32'h0000_4008, 32'hCAFE_F00D, 32'd0, 5, rd, mis, ill);
        check("sw_stall_wdata", mem_wdata, 32'hCAFE_F00D);
        gmin = 0; gmax = 0;

        // Reset while a load waits for data.
        auto_mem = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        issue(1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'h5555_AAAA);
        check("rst_in_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst_pre_addr", mem_addr, 32'h0000_0040);
        check("rst_pre_be", 32'(mem_be), 32'hF);
        #2 rst = 1'b0;
        #1;
        check("rst_async_ready", 32'(req_ready), 32'd1);
        check("rst_async_mem_ctl", 32'({mem_req, mem_we, mem_be}), 32'd0);
        check("rst_async_mem_addr", mem_addr, 32'd0);
        check("rst_async_mem_wdata", mem_wdata, 32'd0);
        check("rst_async_rsp", 32'({rsp_valid, rsp_misaligned, rsp_illegal}), 32'd0);
        check("rst_async_rdata", rsp_rdata, 32'd0);
        exp_rsp_q.delete();
        exp_mem_q.delete();
        word_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (4) begin
            check("rst_late_rvalid_ignored", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        auto_mem = 1'b1;

        // Randomized traffic with random grant/data latency and stray strobes.
        gmin = 0; gmax = 3; rmin = 0; rmax = 3;
        junk = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
        end

        guard = 0;
        while (exp_rsp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_rsp_queue", 32'(exp_rsp_q.size()), 32'd0);
        check("drain_mem_queue", 32'(exp_mem_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
